// File: rtl/servo_pose_controller.sv
// N-channel servo position controller: manual inc/dec stepping with saturation,
// pose recording into a small register memory, and slewed replay with per-pose dwell.
module servo_pose_controller #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned DEFAULT    = 150,
  parameter int unsigned STEP       = 1,
  parameter int unsigned UPPER      = 250,
  parameter int unsigned LOWER      = 50,
  parameter int unsigned TICK_DIV   = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [CHANNELS-1:0]         i_inc,
  input  logic [CHANNELS-1:0]         i_dec,
  input  logic                        i_record,
  input  logic                        i_replay,
  output logic [CHANNELS*WIDTH-1:0]   o_servo,
  output logic                        o_replaying,
  output logic [$clog2(DEPTH):0]      o_tot_state,
  output logic [$clog2(DEPTH):0]      o_current_state,
  output logic                        o_full
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned EXT_W  = WIDTH + 1;
  localparam int unsigned POSE_W = CHANNELS * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REPLAY, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic                rec_pend_q, rep_pend_q;
  logic [WIDTH-1:0]    pos_q [CHANNELS];
  logic [WIDTH-1:0]    pos_d [CHANNELS];
  logic [WIDTH-1:0]    target_c [CHANNELS];
  logic [CNT_W-1:0]    tot_q, tot_d;
  logic [CNT_W-1:0]    cur_q, cur_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                replaying_q, full_q;
  logic [POSE_W-1:0]   mem [DEPTH];
  logic [POSE_W-1:0]   pos_flat_c;
  logic                tick_c, rec_c, rep_c;
  logic                mem_we, rec_ok, all_hit;
  logic [EXT_W-1:0]    p_ext, t_ext;

  // A pulse landing on a tick cycle is serviced on that same tick.
  assign tick_c = (div_q == DIV_W'(TICK_DIV - 1));
  assign rec_c  = rec_pend_q | i_record;
  assign rep_c  = rep_pend_q | i_replay;

  always_comb begin : flatten_c
    pos_flat_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pos_flat_c[c*WIDTH +: WIDTH] = pos_q[c];
      target_c[c] = mem[cur_q[ADDR_W-1:0]][c*WIDTH +: WIDTH];
    end
  end

  always_comb begin : next_c
    state_d = state_q;
    tot_d   = tot_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    mem_we  = 1'b0;
    rec_ok  = 1'b0;
    all_hit = 1'b1;
    p_ext   = '0;
    t_ext   = '0;
    for (int c = 0; c < CHANNELS; c++) pos_d[c] = pos_q[c];

    if (tick_c) begin
      unique case (state_q)
        S_IDLE: begin
          // Record captures the pose before this tick's manual step.
          rec_ok = rec_c && !full_q;
          if (rec_ok) begin
            mem_we = 1'b1;
            tot_d  = tot_q + CNT_W'(1);
          end
          if (rep_c && (rec_ok || (tot_q != '0))) begin
            cur_d   = '0;
            state_d = S_REPLAY;
          end else begin
            for (int c = 0; c < CHANNELS; c++) begin
              p_ext = {1'b0, pos_q[c]};
              if (i_inc[c] && !i_dec[c]) begin
                p_ext    = p_ext + EXT_W'(STEP);
                pos_d[c] = (p_ext > EXT_W'(UPPER)) ? WIDTH'(UPPER) : p_ext[WIDTH-1:0];
              end else if (i_dec[c] && !i_inc[c]) begin
                pos_d[c] = (p_ext < EXT_W'(LOWER) + EXT_W'(STEP)) ?
                           WIDTH'(LOWER) : WIDTH'(p_ext - EXT_W'(STEP));
              end
            end
          end
        end

        S_REPLAY: begin
          if (rep_c) begin
            cur_d   = '0;
            state_d = S_IDLE;
          end else begin
            for (int c = 0; c < CHANNELS; c++) begin
              p_ext = {1'b0, pos_q[c]};
              t_ext = {1'b0, target_c[c]};
              if (p_ext < t_ext) begin
                pos_d[c] = (t_ext - p_ext <= EXT_W'(STEP)) ?
                           target_c[c] : WIDTH'(p_ext + EXT_W'(STEP));
              end else if (p_ext > t_ext) begin
                pos_d[c] = (p_ext - t_ext <= EXT_W'(STEP)) ?
                           target_c[c] : WIDTH'(p_ext - EXT_W'(STEP));
              end
              if (pos_d[c] != target_c[c]) all_hit = 1'b0;
            end
            if (all_hit) begin
              hold_d  = '0;
              state_d = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (rep_c) begin
            cur_d   = '0;
            state_d = S_IDLE;
          end else if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            if (cur_q + CNT_W'(1) < tot_q) begin
              cur_d   = cur_q + CNT_W'(1);
              state_d = S_REPLAY;
            end else begin
              cur_d   = '0;
              state_d = S_IDLE;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin : state_ff
    if (i_rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      rec_pend_q  <= 1'b0;
      rep_pend_q  <= 1'b0;
      tot_q       <= '0;
      cur_q       <= '0;
      hold_q      <= '0;
      replaying_q <= 1'b0;
      full_q      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) pos_q[c] <= WIDTH'(DEFAULT);
    end else begin
      div_q       <= tick_c ? '0 : div_q + DIV_W'(1);
      rec_pend_q  <= tick_c ? 1'b0 : rec_c;
      rep_pend_q  <= tick_c ? 1'b0 : rep_c;
      state_q     <= state_d;
      tot_q       <= tot_d;
      cur_q       <= cur_d;
      hold_q      <= hold_d;
      replaying_q <= (state_d != S_IDLE);
      full_q      <= (tot_d == CNT_W'(DEPTH));
      for (int c = 0; c < CHANNELS; c++) pos_q[c] <= pos_d[c];
    end
  end

  // Pose memory carries no reset; only slots below tot are ever read.
  always_ff @(posedge i_clk) begin : mem_ff
    if (mem_we) mem[tot_q[ADDR_W-1:0]] <= pos_flat_c;
  end

  assign o_servo         = pos_flat_c;
  assign o_replaying     = replaying_q;
  assign o_tot_state     = tot_q;
  assign o_current_state = cur_q;
  assign o_full          = full_q;

endmodule

// File: tb/tb_servo_pose_controller.sv
// Directed bench for servo_pose_controller with an abstract behavioural model
// checked every cycle, plus hand-computed spot checks.
module tb_servo_pose_controller;
  localparam int CH = 4;
  localparam int W = 13;
  localparam int DEPTH = 16;
  localparam int HOLD_TICKS = 4;
  localparam int TICK_DIV = 2;
  localparam int STEP = 1;
  localparam int UP = 250;
  localparam int LO = 50;
  localparam int DEF = 150;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   inc = '0;
  logic [CH-1:0]   dec = '0;
  logic            rec = 1'b0;
  logic            rep = 1'b0;
  logic [CH*W-1:0] servo;
  logic            replaying, full;
  logic [4:0]      tot_state, cur_state;

  servo_pose_controller dut (
    .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_dec(dec),
    .i_record(rec), .i_replay(rep), .o_servo(servo),
    .o_replaying(replaying), .o_tot_state(tot_state),
    .o_current_state(cur_state), .o_full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan(input int c);
    return int'(servo[c*W +: W]);
  endfunction

  // Model: mode 0 = manual, 1 = slewing to a pose, 2 = dwelling on a pose.
  int m_cycle, m_mode, m_tot, m_cur, m_dwell;
  bit m_rec_p, m_rep_p;
  int m_pos [CH];
  int m_mem [DEPTH][CH];

  task automatic model_reset();
    m_cycle = 0; m_mode = 0; m_tot = 0; m_cur = 0; m_dwell = 0;
    m_rec_p = 0; m_rep_p = 0;
    for (int c = 0; c < CH; c++) m_pos[c] = DEF;
  endtask

  task automatic model_update(input bit do_rec, input bit do_rep);
    bit done;
    int diff;
    if (m_mode == 0) begin
      if (do_rec && m_tot < DEPTH) begin
        for (int c = 0; c < CH; c++) m_mem[m_tot][c] = m_pos[c];
        m_tot++;
      end
      if (do_rep && m_tot > 0) begin
        m_cur = 0; m_mode = 1;
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (inc[c] && !dec[c]) m_pos[c] = (m_pos[c] + STEP > UP) ? UP : m_pos[c] + STEP;
          else if (dec[c] && !inc[c]) m_pos[c] = (m_pos[c] - STEP < LO) ? LO : m_pos[c] - STEP;
        end
      end
    end else if (do_rep) begin
      m_mode = 0; m_cur = 0;
    end else if (m_mode == 1) begin
      done = 1;
      for (int c = 0; c < CH; c++) begin
        diff = m_mem[m_cur][c] - m_pos[c];
        if (diff > STEP) m_pos[c] += STEP;
        else if (diff < -STEP) m_pos[c] -= STEP;
        else m_pos[c] = m_mem[m_cur][c];
        if (m_pos[c] != m_mem[m_cur][c]) done = 0;
      end
      if (done) begin m_mode = 2; m_dwell = 0; end
    end else begin
      m_dwell++;
      if (m_dwell == HOLD_TICKS) begin
        if (m_cur < m_tot - 1) begin m_cur++; m_mode = 1; end
        else begin m_cur = 0; m_mode = 0; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else begin
      bit r, p;
      r = m_rec_p || rec;
      p = m_rep_p || rep;
      if (m_cycle % TICK_DIV == TICK_DIV - 1) begin
        m_rec_p = 0; m_rep_p = 0;
        model_update(r, p);
      end else begin
        m_rec_p = r; m_rep_p = p;
      end
      m_cycle++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int c = 0; c < CH; c++) check($sformatf("model_ch%0d", c), chan(c), m_pos[c]);
      check("model_replaying", replaying, (m_mode != 0) ? 1 : 0);
      check("model_tot", tot_state, m_tot);
      check("model_cur", cur_state, m_cur);
      check("model_full", full, (m_tot == DEPTH) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic keys(input logic [CH-1:0] i, input logic [CH-1:0] d, input int n);
    inc = i; dec = d; cyc(n); inc = '0; dec = '0;
  endtask

  task automatic pulse_rec();
    rec = 1'b1; cyc(1); rec = 1'b0; cyc(2);
  endtask

  task automatic pulse_rep();
    rep = 1'b1; cyc(1); rep = 1'b0;
  endtask

  task automatic wait_replay(input logic lvl, input int budget, input string name);
    int k = 0;
    while (replaying !== lvl && k < budget) begin cyc(1); k++; end
    check(name, replaying, lvl);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int c = 0; c < CH; c++) check($sformatf("%s_ch%0d", tag, c), chan(c), DEF);
    check({tag, "_replaying"}, replaying, 0);
    check({tag, "_tot"}, tot_state, 0);
    check({tag, "_cur"}, cur_state, 0);
    check({tag, "_full"}, full, 0);
  endtask

  initial begin
    int k;
    @(posedge clk); #2;
    cmp_en = 1'b1;
    cyc(2);
    check_reset_vals("reset");
    rst = 1'b0;
    cyc(1);

    // Manual stepping: 20 cycles at TICK_DIV=2 is 10 ticks.
    keys(4'b0001, 4'b0000, 20);
    check("inc_ch0", chan(0), 160);
    check("inc_ch1_untouched", chan(1), 150);

    // Saturation and simultaneous keys.
    keys(4'b0010, 4'b0000, 400);
    check("sat_upper_ch1", chan(1), 250);
    keys(4'b0000, 4'b0010, 500);
    check("sat_lower_ch1", chan(1), 50);
    keys(4'b0100, 4'b0100, 10);
    check("both_keys_ch2", chan(2), 150);

    // Poses A=(160,150,150,150) and B=(140,170,150,150).
    keys(4'b0010, 4'b0000, 200);
    check("poseA_ch1", chan(1), 150);
    pulse_rec();
    keys(4'b0000, 4'b0001, 40);
    keys(4'b0010, 4'b0000, 40);
    check("poseB_ch0", chan(0), 140);
    check("poseB_ch1", chan(1), 170);
    pulse_rec();
    check("tot_two", tot_state, 2);

    pulse_rep();
    wait_replay(1'b1, 4, "replay_start");
    wait_replay(1'b0, 400, "replay_end");
    check("replay_end_ch0", chan(0), 140);
    check("replay_end_ch1", chan(1), 170);
    check("replay_end_cur", cur_state, 0);

    // Abort mid-slew with inc held throughout the replay.
    pulse_rep();
    wait_replay(1'b1, 4, "abort_start");
    inc = 4'b1111;
    cyc(10);
    inc = '0;
    pulse_rep();
    wait_replay(1'b0, 4, "abort_idle");
    cyc(10);
    check("abort_cur", cur_state, 0);
    check("abort_ch2_no_manual", chan(2), 150);
    check("abort_ch3_no_manual", chan(3), 150);

    // Fill memory, then a dropped 17th record.
    for (int i = 0; i < 14; i++) pulse_rec();
    check("full_tot", tot_state, 16);
    check("full_flag", full, 1);
    keys(4'b0100, 4'b0000, 20);
    check("pre_drop_ch2", chan(2), 160);
    pulse_rec();
    check("drop_tot", tot_state, 16);
    pulse_rep();
    wait_replay(1'b1, 4, "full_replay_start");
    wait_replay(1'b0, 1500, "full_replay_end");
    check("slot15_ch2", chan(2), 150);

    // Reset while dwelling on pose A.
    pulse_rep();
    wait_replay(1'b1, 4, "hold_replay_start");
    k = 0;
    while (!(chan(0) == 160 && chan(1) == 150) && k < 200) begin cyc(1); k++; end
    check("reach_poseA", (chan(0) == 160 && chan(1) == 150) ? 1 : 0, 1);
    cyc(2);
    check("in_hold", replaying, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    cyc(2);
    rst = 1'b0;
    pulse_rep();
    cyc(6);
    check("empty_replay_ignored", replaying, 0);

    // Record and replay on the same tick.
    rec = 1'b1; rep = 1'b1;
    cyc(1);
    rec = 1'b0; rep = 1'b0;
    wait_replay(1'b1, 4, "recrep_start");
    check("recrep_tot", tot_state, 1);
    wait_replay(1'b0, 40, "recrep_end");
    check("recrep_ch0", chan(0), 150);
    cyc(2);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_pose_controller.md
# servo_pose_controller

Parametrised N-channel servo position controller with pose recording and automatic replay. It sits between the keyboard status decoder and the PWM generators. Manual mode steps each channel's position from inc/dec key levels with saturation. Recorded poses can be replayed as a slewed sequence with a per-pose dwell.

## Interface
Parameters:
- CHANNELS, 4: number of servo channels.
- WIDTH, 13: position width in bits.
- DEFAULT, 150: reset position, all channels.
- STEP, 1: position change per tick (manual and slew).
- UPPER, 250: saturation upper limit.
- LOWER, 50: saturation lower limit.
- TICK_DIV, 2: i_clk cycles per update tick (≥1).
- DEPTH, 16: pose memory slots.
- HOLD_TICKS, 4: dwell ticks once a pose is reached during replay.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge. One clock only; no derived clocks.
- i_rst  in  1  asynchronous, active-high reset.
- i_inc  in  CHANNELS  level; bit c raises channel c.
- i_dec  in  CHANNELS  level; bit c lowers channel c.
- i_record  in  1  single-cycle pulse; store the current pose.
- i_replay  in  1  single-cycle pulse; start replay, or abort it if already running.
- o_servo  out  CHANNELS*WIDTH  positions; channel c occupies bits [c*WIDTH +: WIDTH].
- o_replaying  out  1  high while in REPLAY or HOLD.
- o_tot_state  out  $clog2(DEPTH)+1  number of stored poses.
- o_current_state  out  $clog2(DEPTH)+1  index of the pose being replayed; 0 outside replay.
- o_full  out  1  o_tot_state == DEPTH.

## Operation
Tick generation:
- Divider counts 0..TICK_DIV-1.
- tick = (count == TICK_DIV-1).
- All state and position updates occur only on tick cycles.

Pending flags:
- i_record and i_replay pulses set rec_pend / rep_pend on any cycle.
- The flags are consumed and cleared on the next tick.

FSM states: IDLE (manual), REPLAY (slewing), HOLD (dwell).

IDLE, per channel on tick:
- inc only: pos ← min(pos+STEP, UPPER).
- dec only: pos ← max(pos−STEP, LOWER).
- Both inc and dec, or neither: no change.
- Arithmetic is done in WIDTH+1 bits so no wrap occurs before the clamp.
- rec_pend and not full: mem[tot] ← all positions, taken before this tick's inc/dec is applied; tot ← tot+1.
- rec_pend and full: record is dropped; memory and tot are unchanged.
- rep_pend and tot>0: current ← 0; go to REPLAY; inc/dec are ignored on this tick.
- rep_pend and tot=0: replay is ignored.
- rec_pend and rep_pend on the same tick: record is processed first, then replay starts from pose 0 including the new pose.

REPLAY, per tick:
- Each channel moves toward mem[current][c] by up to STEP, with no overshoot. If the difference is below STEP, pos ← target.
- When all channels equal their targets after the update, hold_cnt ← 0 and go to HOLD.

HOLD, per tick:
- hold_cnt increments.
- When hold_cnt reaches HOLD_TICKS−1:
  - current < tot−1: current+1, go to REPLAY.
  - Otherwise: current ← 0, go to IDLE.

Replay-time inputs:
- i_inc, i_dec and rec_pend are ignored; rec_pend is cleared.
- rep_pend aborts: go to IDLE, positions hold their present values, current ← 0.

Memory:
- Register array of DEPTH × CHANNELS*WIDTH.
- Not reset; only slots below tot are ever read.

## Timing
Reset values while i_rst is high:
- All o_servo channels = DEFAULT.
- o_replaying=0, o_tot_state=0, o_current_state=0, o_full=0.
- FSM in IDLE; divider, pending flags and hold_cnt = 0.

Reset mid-replay returns to these values immediately; asynchronous, with no tick wait.

Latency:
- Outputs are registered.
- A position change appears in the cycle after the tick edge.
- A pulse is serviced at the first tick at or after it, so worst-case latency is TICK_DIV cycles.

o_replaying rises on the same edge that enters REPLAY.

A pose whose targets already equal the current positions takes 1 REPLAY tick plus HOLD_TICKS ticks.

## Test plan
1. Reset, TICK_DIV=2 -> all channels read 150; hold i_inc[0] for 20 cycles -> ch0=160, other channels 150.
2. Saturation:
   - Hold i_inc[1] for 400 cycles -> ch1=250 and stays there.
   - Hold i_dec[1] for 500 cycles -> ch1=50.
   - i_inc[2] and i_dec[2] held together -> ch2 unchanged.
3. Record and replay:
   - Set pose A=(160,150,150,150) and record; set pose B=(140,170,150,150) and record -> tot=2.
   - Pulse i_replay -> channels slew 1 per tick to A, dwell 4 ticks, slew to B, dwell 4 ticks.
   - Then o_replaying=0, positions hold at B, current=0.
4. Full memory: 16 records followed by a 17th -> tot=16, o_full=1, slot 15 unchanged.
5. Replay abort and blocked inputs:
   - Pulse i_replay mid-slew -> IDLE with positions frozen.
   - i_inc held during replay -> no manual effect.
   - i_replay with tot=0 -> stays IDLE.
6. Asserting i_rst during HOLD -> all outputs return to reset values within the same cycle; tot=0.
